// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder (LSB first, one full-adder cell) with valid/ready handshakes.
// Optional registered carry_out port is enabled by defining SERIAL_ADDER_CARRY_OUT_EN.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] sum,
    output logic             out_valid,
    input  logic             out_ready
`ifdef SERIAL_ADDER_CARRY_OUT_EN
    ,
    output logic             carry_out
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             s_bit;
    logic             maj;
`ifdef SERIAL_ADDER_CARRY_OUT_EN
    logic             cout_q, cout_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SERIAL_ADDER_CARRY_OUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cout_q <= 1'b0;
        end else begin
            cout_q <= cout_d;
        end
    end

    assign carry_out = cout_q;
`endif

    assign s_bit = a_q[0] ^ b_q[0] ^ carry_q;
    assign maj   = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_CARRY_OUT_EN
        cout_d  = cout_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at sum[0].
                sum_d   = {s_bit, sum_q[WIDTH-1:1]};
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = maj;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
`ifdef SERIAL_ADDER_CARRY_OUT_EN
                    cout_d  = maj;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vector table, corner sequences and random ops.
// Define SERIAL_ADDER_CARRY_OUT_EN for both files to exercise the carry_out port.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] sum;
    logic         out_valid;
    logic         out_ready;
`ifdef SERIAL_ADDER_CARRY_OUT_EN
    logic         carry_out;
`endif

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .sum       (sum),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef SERIAL_ADDER_CARRY_OUT_EN
        ,
        .carry_out (carry_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         c;
        int           hold;
        bit           noisy;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts at posedge+1 with the DUT idle; ends the same way.
    task automatic transact(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp_s, input logic exp_c,
                            input int hold, input bit noisy, input string tag);
        int  n;
        bit  ready_seen;
        chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        a_in      = a;
        b_in      = b;
        out_ready = (hold == 0);
        step();
        n = 0;
        ready_seen = 1'b0;
        while (!out_valid && n < W + 4) begin
            if (in_ready) ready_seen = 1'b1;
            in_valid = noisy ? 1'b1 : 1'($urandom_range(0, 1));
            a_in     = W'($urandom);
            b_in     = W'($urandom);
            step();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(W));
        chk({tag, "_busy_in_ready"}, 32'(ready_seen), 32'd0);
        chk({tag, "_sum"}, 32'(sum), 32'(exp_s));
`ifdef SERIAL_ADDER_CARRY_OUT_EN
        chk({tag, "_carry_out"}, 32'(carry_out), 32'(exp_c));
`else
        if (exp_c === 1'bx) $display("unexpected x carry in %s", tag);
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = noisy ? 1'b1 : 1'($urandom_range(0, 1));
            step();
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_sum"}, 32'(sum), 32'(exp_s));
        end
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_post_ready"}, 32'(in_ready), 32'd1);
        step();
        // A queued or spurious second accept would show up as in_ready low here.
        chk({tag, "_single_result"}, 32'({in_ready, out_valid}), 32'b10);
    endtask

    initial begin
        logic [W:0] full;
        logic [W-1:0] ra, rb;

        tbl[0] = '{a: 8'h99, b: 8'h33, s: 8'hCC, c: 1'b0, hold: 0, noisy: 1'b0};
        tbl[1] = '{a: 8'hB5, b: 8'h37, s: 8'hEC, c: 1'b0, hold: 0, noisy: 1'b0};
        tbl[2] = '{a: 8'hE9, b: 8'h33, s: 8'h1C, c: 1'b1, hold: 1, noisy: 1'b0};
        tbl[3] = '{a: 8'hFF, b: 8'h01, s: 8'h00, c: 1'b1, hold: 5, noisy: 1'b1};
        tbl[4] = '{a: 8'h80, b: 8'h80, s: 8'h00, c: 1'b1, hold: 0, noisy: 1'b1};
        tbl[5] = '{a: 8'h00, b: 8'h00, s: 8'h00, c: 1'b0, hold: 2, noisy: 1'b0};
        tbl[6] = '{a: 8'hFF, b: 8'hFF, s: 8'hFE, c: 1'b1, hold: 0, noisy: 1'b0};
        tbl[7] = '{a: 8'h12, b: 8'h34, s: 8'h46, c: 1'b0, hold: 0, noisy: 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a_in = '0;
        b_in = '0;
        #12;
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef SERIAL_ADDER_CARRY_OUT_EN
        chk("reset_carry_out", 32'(carry_out), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            transact(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, tbl[i].hold, tbl[i].noisy,
                     $sformatf("vec%0d", i));
        end

        // Mid-operation asynchronous reset: 0x12+0x34 aborted after 3 BUSY edges.
        in_valid = 1'b1;
        a_in = 8'h12;
        b_in = 8'h34;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        chk("midrst_busy", 32'({in_ready, out_valid}), 32'b00);
        #2 rst = 1'b1;
        #1;
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        #1 rst = 1'b0;
        out_ready = 1'b0;
        step();
        transact(8'h12, 8'h34, 8'h46, 1'b0, 0, 1'b0, "midrst_redo");

        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            full = {1'b0, ra} + {1'b0, rb};
            transact(ra, rb, full[W-1:0], full[W], int'($urandom_range(0, 3)), 1'b0,
                     $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
